uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//  Serialises one NB_DATA-bit word onto the UART line as an 8N1-style frame.
//  The frame is: start bit, data bits LSB first, optional parity bit, stop period.
//  It is the transmit partner of the UART receiver and shares the same s_tick
//  oversampling baud generator. It sits between the host/ALU interface and the
//  tx pin.
// PARAMETERS
//  NB_DATA    8   data bits per frame
//  S_TICK     16  s_tick pulses per start/data/parity bit
//  SB_TICK    16  s_tick pulses in stop period (16 = 1 stop bit, 32 = 2)
//  PARITY_EN  0   1 = insert parity bit after data bits
//  PARITY_ODD 0   0 = even parity, 1 = odd parity (only when PARITY_EN=1)
// PORTS
//  clk          in   1        system clock, rising edge
//  reset        in   1        asynchronous, active-low; 0 = reset
//  s_tick       in   1        baud-oversample strobe, 1 clk wide
//  tx_start     in   1        request to send; sampled only in IDLE
//  data_in      in   NB_DATA  word to send; captured on accepted tx_start
//  tx           out  1        serial line, registered, idle high
//  tx_busy      out  1        1 from cycle after accept until frame done
//  tx_done_tick out  1        1-clk pulse at end of stop period
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, tx=1, tx_busy=0, tx_done_tick=0,
//   tick/bit counters=0, shift reg=0. Release is synchronous to clk.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  IDLE: tx=1. On tx_start=1, the next clk does the following:
//   - latch data_in into the shift reg and compute parity from it
//   - tick=0, state=START
//   - tx goes 0 and tx_busy goes 1 on that same edge.
//  tx_start in any other state is ignored; it is not queued.
//  The tick counter only advances on cycles with s_tick=1.
//   Width is clog2(max(S_TICK,SB_TICK)).
//  START: tx=0. On s_tick with tick==S_TICK-1: tick=0, bit=0, state=DATA,
//   tx=shift[0].
//  DATA: tx=shift[0]. On s_tick with tick==S_TICK-1: tick=0, shift>>=1.
//   - If bit==NB_DATA-1: go to PARITY if PARITY_EN, else STOP.
//   - Otherwise bit+=1.
//   - Bit counter width is clog2(NB_DATA). It is compared, never wrapped.
//  PARITY: tx = ^data ^ PARITY_ODD, using the word latched at accept.
//   On s_tick with tick==S_TICK-1: tick=0, state=STOP.
//  STOP: tx=1. On s_tick with tick==SB_TICK-1: state=IDLE, tx_busy=0,
//   tx_done_tick=1 for exactly one clk (registered, same edge as busy drop).
//  Frame length = S_TICK*(1+NB_DATA+PARITY_EN)+SB_TICK s_tick pulses.
//  Back-to-back frames:
//   - tx_start may be high in the cycle tx_done_tick=1 (state already IDLE).
//   - It is accepted there, so the next start bit follows with no idle gap.
//  tx changes only on clk edges. There are no combinational paths from inputs
//   to tx, tx_busy or tx_done_tick.
//  If s_tick is held 0, the FSM holds state and tx level indefinitely.
//  Reset mid-frame: tx returns to 1 immediately (async) and the frame is
//   abandoned. No tx_done_tick is issued.
//  data_in changing after accept has no effect on the frame in progress.
// TESTING
//  T1: defaults, s_tick every 4 clk, send 0xA5 -> tx =
//   0, then 1,0,1,0,0,1,0,1, then 1. Each bit lasts 16 s_tick;
//   tx_done_tick once after 160 s_tick; tx_busy high throughout.
//  T2: loopback tx->uart_rx, send 0x00, 0xFF, 0x3C -> rx data_out matches
//   each; one rx_done_tick per frame.
//  T3: tx_start pulsed mid-frame with data_in=0x55 while sending 0x81 ->
//   only 0x81 sent; no second frame.
//  T4: tx_start held high continuously, data 0x12 then 0x34 -> two frames
//   with no idle bit between stop and next start.
//  T5: PARITY_EN=1, send 0x07 -> parity bit 1 (even); with PARITY_ODD=1 -> 0.
//   Frame is 176 s_tick.
//  T6: reset low during bit 3 of 0xF0 -> tx=1 asynchronously, busy=0, no done.
//   Next tx_start of 0x0F is sent cleanly.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: serialises one NB_DATA-bit word onto the UART line.
// Frame: start bit (0), NB_DATA data bits LSB first, optional parity bit, stop period (1).
// Timing is derived from the shared s_tick oversampling strobe; every bit lasts S_TICK
// strobes and the stop period lasts SB_TICK strobes.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   s_tick       baud-oversample strobe, one clk wide
//   tx_start     send request, only honoured while idle
//   data_in      word to send, captured when tx_start is accepted
//   tx           registered serial line, idles high
//   tx_busy      high from the cycle after accept until the frame is done
//   tx_done_tick one-clk pulse at the end of the stop period
module uart_tx #(
  parameter int unsigned NB_DATA    = 8,
  parameter int unsigned S_TICK     = 16,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_tick,
  input  logic               tx_start,
  input  logic [NB_DATA-1:0] data_in,
  output logic               tx,
  output logic               tx_busy,
  output logic               tx_done_tick
);

  localparam int unsigned MaxTick = (S_TICK > SB_TICK) ? S_TICK : SB_TICK;
  localparam int unsigned TickW   = (MaxTick > 1) ? $clog2(MaxTick) : 1;
  localparam int unsigned BitW    = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [TickW-1:0]   tick_q, tick_d;
  logic [BitW-1:0]    bit_q, bit_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic bit_last;
  logic stop_last;

  assign bit_last  = (tick_q == TickW'(S_TICK - 1));
  assign stop_last = (tick_q == TickW'(SB_TICK - 1));

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (tx_start) begin
          shift_d = data_in;
          // Parity is fixed at accept so later data_in changes cannot disturb it.
          par_d   = (^data_in) ^ (PARITY_ODD != 0);
          tick_d  = '0;
          state_d = StStart;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      StStart: begin
        if (s_tick) begin
          if (bit_last) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = StData;
            tx_d    = shift_q[0];
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end

      StData: begin
        if (s_tick) begin
          if (bit_last) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == BitW'(NB_DATA - 1)) begin
              if (PARITY_EN != 0) begin
                state_d = StParity;
                tx_d    = par_q;
              end else begin
                state_d = StStop;
                tx_d    = 1'b1;
              end
            end else begin
              bit_d = bit_q + BitW'(1);
              tx_d  = shift_d[0];
            end
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end

      StParity: begin
        if (s_tick) begin
          if (bit_last) begin
            tick_d  = '0;
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end

      StStop: begin
        if (s_tick) begin
          if (stop_last) begin
            tick_d  = '0;
            state_d = StIdle;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end

      default: begin
        state_d = StIdle;
        tick_d  = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule
